// File: rtl/rx_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_fsm_pkg
//  Description : Chiplet flit/header types, widths and header helpers for rx_fsm.
//  Revision    : 1.0  initial release
// ============================================================================
package rx_fsm_pkg;

    localparam int PKT_ID_WIDTH     = 2;
    localparam int NODE_ID_WIDTH    = 4;
    localparam int PKT_LENGTH_WIDTH = 8;

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        FMT_SWITCH_CFG = 4'h0,
        FMT_LONG_READ  = 4'h1,
        FMT_LONG_WRITE = 4'h2,
        FMT_MSG        = 4'h3
    } format_e;

    typedef struct packed {
        format_e     format;
        logic [6:0]  length;
        logic [20:0] addr;
    } long_hdr_t;

    typedef struct packed {
        logic                     vc;
        logic [PKT_ID_WIDTH-1:0]  id;
        logic [NODE_ID_WIDTH-1:0] req;
    } metadata_t;

    typedef struct packed {
        metadata_t   metadata;
        logic [31:0] payload;
    } flit_t;

    // Total flits including header: config = header + 1 word; reads carry only a CRC;
    // every other format carries `length` data words plus the CRC.
    function automatic logic [PKT_LENGTH_WIDTH-1:0] expected_num_flits(input logic [31:0] payload);
        long_hdr_t hdr;
        hdr = long_hdr_t'(payload);
        case (hdr.format)
            FMT_SWITCH_CFG: return PKT_LENGTH_WIDTH'(2);
            FMT_LONG_READ:  return PKT_LENGTH_WIDTH'(2);
            default:        return PKT_LENGTH_WIDTH'(hdr.length) + PKT_LENGTH_WIDTH'(2);
        endcase
    endfunction

    function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_fsm_if
//  Description : Write bus from the RX packet engine into endpoint RX memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface rx_fsm_if;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic        request_stall;

    modport master (output addr, wen, wdata, strobe, input  request_stall);
    modport slave  (input  addr, wen, wdata, strobe, output request_stall);
endinterface
`default_nettype wire

// File: rtl/rx_fsm_crc.sv
`default_nettype none
// ============================================================================
//  Module      : socetlib_crc
//  Description : Word-wide CRC-32 accumulator; clear and update may coincide.
//  Revision    : 1.0  initial release
// ============================================================================
module socetlib_crc
    import rx_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        update,
    input  logic [31:0] data_in,
    output logic [31:0] crc_out,
    output logic        done
);

    logic [31:0] crc_q;
    logic        done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q  <= CRC_INIT;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b1;
            if (update) begin
                crc_q <= crc32_word(clear ? CRC_INIT : crc_q, data_in);
            end else if (clear) begin
                crc_q <= CRC_INIT;
            end
        end
    end

    assign crc_out = crc_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: rtl/rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : rx_fsm
//  Description : Receive packet engine: writes flits into RX slots, checks CRC.
//  Revision    : 1.0  initial release
// ============================================================================
module rx_fsm
    import rx_fsm_pkg::*;
#(
    parameter int          NUM_MSGS     = 4,
    parameter logic [31:0] RX_BASE_ADDR = 32'h2000,
    parameter int          SLOT_WORDS   = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flit_valid,
    input  flit_t                       flit,
    output logic                        flit_ready,
    input  logic [NUM_MSGS-1:0]         slot_free,
    rx_fsm_if.master                    rx_if,
    output logic                        pkt_done,
    output logic                        pkt_err,
    output logic [PKT_ID_WIDTH-1:0]     pkt_id,
    output logic [NODE_ID_WIDTH-1:0]    pkt_req,
    output logic [PKT_LENGTH_WIDTH-1:0] pkt_words
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [31:0]                 SLOT_BYTES = 32'(SLOT_WORDS * 4);
    localparam logic [PKT_LENGTH_WIDTH-1:0] LEN_ONE    = PKT_LENGTH_WIDTH'(1);

    state_e                      state_q;
    logic [PKT_ID_WIDTH-1:0]     id_q;
    logic [NODE_ID_WIDTH-1:0]    req_q;
    format_e                     fmt_q;
    logic [PKT_LENGTH_WIDTH-1:0] rem_q, rem_d;
    logic [PKT_LENGTH_WIDTH-1:0] wcnt_q, wcnt_d;
    logic                        err_q, err_d;
    logic                        pkt_done_q, pkt_err_q;
    logic [PKT_ID_WIDTH-1:0]     pkt_id_q;
    logic [NODE_ID_WIDTH-1:0]    pkt_req_q;
    logic [PKT_LENGTH_WIDTH-1:0] pkt_words_q;

    long_hdr_t                   w_hdr;
    logic [PKT_LENGTH_WIDTH-1:0] w_hdr_rem;
    logic                        w_slot_free;
    logic                        w_crc_flit;
    logic                        w_wen;
    logic [31:0]                 w_addr;
    logic                        w_crc_clear, w_crc_update, w_crc_ready;
    logic [31:0]                 w_crc_out;
    logic                        w_unused_bits;

    function automatic logic [31:0] slot_base(input logic [PKT_ID_WIDTH-1:0] id);
        return RX_BASE_ADDR + 32'(id) * SLOT_BYTES;
    endfunction

    assign w_hdr         = long_hdr_t'(flit.payload);
    assign w_hdr_rem     = expected_num_flits(flit.payload) - LEN_ONE;
    assign w_slot_free   = (32'(flit.metadata.id) < 32'(NUM_MSGS)) && slot_free[flit.metadata.id];
    assign w_crc_flit    = (state_q == S_DATA) && (rem_q == LEN_ONE) && (fmt_q != FMT_SWITCH_CFG);
    assign w_unused_bits = ^{flit.metadata.vc, w_hdr.length, w_hdr.addr};

    // Handshake and write port are purely combinational so write and accept share a cycle.
    always_comb begin
        flit_ready   = 1'b0;
        w_wen        = 1'b0;
        w_addr       = RX_BASE_ADDR;
        w_crc_clear  = 1'b0;
        w_crc_update = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    w_crc_clear = 1'b1;
                    if (flit_valid) w_addr = slot_base(flit.metadata.id);
                    w_wen        = flit_valid && w_slot_free;
                    flit_ready   = w_wen && !rx_if.request_stall;
                    w_crc_update = flit_ready;
                end
                S_DATA: begin
                    w_addr = slot_base(id_q) + (32'(wcnt_q) << 2);
                    if (w_crc_flit) begin
                        flit_ready = flit_valid && w_crc_ready;
                    end else begin
                        w_wen        = flit_valid && w_crc_ready;
                        flit_ready   = w_wen && !rx_if.request_stall;
                        w_crc_update = flit_ready;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_if.wen    = w_wen;
    assign rx_if.addr   = w_addr;
    assign rx_if.wdata  = w_wen ? flit.payload : 32'h0;
    assign rx_if.strobe = w_wen ? 4'hF : 4'h0;

    always_comb begin
        err_d  = err_q
               | (flit.metadata.id  != id_q)
               | (flit.metadata.req != req_q)
               | (w_crc_flit && (flit.payload != w_crc_out));
        wcnt_d = w_crc_flit ? wcnt_q : wcnt_q + LEN_ONE;
        rem_d  = rem_q - LEN_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            req_q       <= '0;
            fmt_q       <= FMT_SWITCH_CFG;
            rem_q       <= '0;
            wcnt_q      <= '0;
            err_q       <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
            pkt_id_q    <= '0;
            pkt_req_q   <= '0;
            pkt_words_q <= '0;
        end else begin
            pkt_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flit_ready) begin
                        id_q   <= flit.metadata.id;
                        req_q  <= flit.metadata.req;
                        fmt_q  <= w_hdr.format;
                        rem_q  <= w_hdr_rem;
                        wcnt_q <= LEN_ONE;
                        err_q  <= 1'b0;
                        if (w_hdr_rem == '0) begin
                            state_q     <= S_DONE;
                            pkt_done_q  <= 1'b1;
                            pkt_err_q   <= 1'b0;
                            pkt_id_q    <= flit.metadata.id;
                            pkt_req_q   <= flit.metadata.req;
                            pkt_words_q <= LEN_ONE;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (flit_ready) begin
                        rem_q  <= rem_d;
                        wcnt_q <= wcnt_d;
                        err_q  <= err_d;
                        if (rem_d == '0) begin
                            state_q     <= S_DONE;
                            pkt_done_q  <= 1'b1;
                            pkt_err_q   <= err_d;
                            pkt_id_q    <= id_q;
                            pkt_req_q   <= req_q;
                            pkt_words_q <= wcnt_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    err_q     <= 1'b0;
                    pkt_err_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pkt_done  = pkt_done_q;
    assign pkt_err   = pkt_err_q;
    assign pkt_id    = pkt_id_q;
    assign pkt_req   = pkt_req_q;
    assign pkt_words = pkt_words_q;

    socetlib_crc RX_CRC (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_crc_clear),
        .update  (w_crc_update),
        .data_in (flit.payload),
        .crc_out (w_crc_out),
        .done    (w_crc_ready)
    );

endmodule
`default_nettype wire

// File: tb/tb_rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_fsm
//  Description : Scoreboard bench for rx_fsm with a packet-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rx_fsm;
    import rx_fsm_pkg::*;

    localparam logic [31:0] BASE   = 32'h2000;
    localparam logic [31:0] STRIDE = 32'd512;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic       err;
        logic [1:0] id;
        logic [3:0] req;
        logic [7:0] words;
        int         cyc;
    } done_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flit_valid = 1'b0;
    flit_t       flit = '0;
    logic        flit_ready;
    logic [3:0]  slot_free = 4'hF;
    logic        stall = 1'b0;
    logic        pkt_done, pkt_err;
    logic [1:0]  pkt_id;
    logic [3:0]  pkt_req;
    logic [7:0]  pkt_words;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    wr_t         wq[$];
    done_t       dq[$];
    flit_t       pf[$];
    bit          pw[$];
    logic [31:0] pa[$];
    done_t       pend;

    rx_fsm_if rx_if ();
    assign rx_if.request_stall = stall;

    rx_fsm #(.NUM_MSGS(4), .RX_BASE_ADDR(32'h2000), .SLOT_WORDS(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .flit_valid (flit_valid),
        .flit       (flit),
        .flit_ready (flit_ready),
        .slot_free  (slot_free),
        .rx_if      (rx_if),
        .pkt_done   (pkt_done),
        .pkt_err    (pkt_err),
        .pkt_id     (pkt_id),
        .pkt_req    (pkt_req),
        .pkt_words  (pkt_words)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bit-parallel formulation of MSB-first CRC-32 over one aligned word.
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c ^ d;
        for (int k = 0; k < 32; k++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        return r;
    endfunction

    // Packet model: header + data words (all written), then a CRC flit unless config.
    task automatic build_pkt(input int id, input int req, input format_e fmt,
                             input int ndata, input bit corrupt, input int bad_idx);
        logic [31:0] crc, base, hdrw;
        flit_t       f;
        wr_t         w;
        int          nd;
        bit          has_crc, mism;
        pf.delete(); pw.delete(); pa.delete();
        has_crc = (fmt != FMT_SWITCH_CFG);
        nd      = (fmt == FMT_SWITCH_CFG) ? 1 : ((fmt == FMT_LONG_READ) ? 0 : ndata);
        base    = BASE + 32'(id) * STRIDE;
        hdrw    = {4'(fmt), (has_crc && fmt != FMT_LONG_READ) ? 7'(nd) : 7'($urandom), 21'($urandom)};
        crc     = 32'hFFFF_FFFF;
        mism    = 1'b0;
        for (int k = 0; k <= nd + (has_crc ? 1 : 0); k++) begin
            f.metadata.vc  = 1'($urandom);
            f.metadata.id  = 2'(id);
            f.metadata.req = 4'(req);
            if (k == 0)       f.payload = hdrw;
            else if (k <= nd) f.payload = $urandom;
            else              f.payload = crc ^ {31'b0, corrupt};
            if (k > 0 && k == bad_idx) begin
                mism = 1'b1;
                if (bad_idx % 2 == 1) f.metadata.id  = f.metadata.id ^ 2'd2;
                else                  f.metadata.req = f.metadata.req ^ 4'h5;
            end
            pf.push_back(f);
            pa.push_back(base + 32'(4 * k));
            if (k <= nd) begin
                crc    = ref_crc(crc, f.payload);
                w.addr = base + 32'(4 * k);
                w.data = f.payload;
                wq.push_back(w);
                pw.push_back(1'b1);
            end else begin
                pw.push_back(1'b0);
            end
        end
        pend.err   = (has_crc && corrupt) || mism;
        pend.id    = 2'(id);
        pend.req   = 4'(req);
        pend.words = 8'(nd + 1);
        pend.cyc   = 0;
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic send_flit(input int i, input int stall_n);
        int    sn, t;
        bit    acc;
        done_t d;
        sn = stall_n; t = 0; acc = 1'b0;
        flit = pf[i]; flit_valid = 1'b1; stall = (sn > 0);
        while (!acc && t < 100) begin
            @(negedge clk);
            if (stall && pw[i]) begin
                chk("stall_ready", flit_ready, 0);
                chk("stall_wen", rx_if.wen, 1);
                chk("stall_addr", rx_if.addr, pa[i]);
                chk("stall_wdata", rx_if.wdata, pf[i].payload);
                sn--;
            end
            if (flit_ready) begin
                acc = 1'b1;
                if (i == pf.size() - 1) begin
                    d = pend;
                    d.cyc = cyc + 1;
                    dq.push_back(d);
                end
            end
            t++;
            @(posedge clk); #1;
            stall = (sn > 0);
        end
        if (!acc) chk("accept_timeout", acc, 1);
        flit_valid = 1'b0;
        stall = 1'b0;
    endtask

    task automatic send_pkt(input int stall_idx, input int stall_n, input int gap_max);
        int g;
        for (int i = 0; i < pf.size(); i++) begin
            g = $urandom_range(0, gap_max);
            if (i == 0 && stall_idx == 0 && stall_n > 0 && g == 0) g = 1;
            repeat (g) begin @(posedge clk); #1; end
            send_flit(i, (i == stall_idx) ? stall_n : 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_ready"},  flit_ready, 0);
        chk({nm, "_wen"},    rx_if.wen, 0);
        chk({nm, "_addr"},   rx_if.addr, 32'h2000);
        chk({nm, "_wdata"},  rx_if.wdata, 0);
        chk({nm, "_strobe"}, rx_if.strobe, 0);
        chk({nm, "_done"},   pkt_done, 0);
        chk({nm, "_err"},    pkt_err, 0);
        chk({nm, "_id"},     pkt_id, 0);
        chk({nm, "_req"},    pkt_req, 0);
        chk({nm, "_words"},  pkt_words, 0);
    endtask

    // Monitor: pops the scoreboard on every accepted write and every completion.
    always @(negedge clk) begin
        wr_t   w;
        done_t d;
        if (!rst) begin
            if (rx_if.wen && !stall) begin
                chk("write_expected", wq.size() != 0, 1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    chk("wr_addr", rx_if.addr, w.addr);
                    chk("wr_data", rx_if.wdata, w.data);
                    chk("wr_strobe", rx_if.strobe, 4'hF);
                end
            end
            if (pkt_done) begin
                chk("done_ready_low", flit_ready, 0);
                chk("done_expected", dq.size() != 0, 1);
                if (dq.size() != 0) begin
                    d = dq.pop_front();
                    chk("done_err", pkt_err, d.err);
                    chk("done_id", pkt_id, d.id);
                    chk("done_req", pkt_req, d.req);
                    chk("done_words", pkt_words, d.words);
                    chk("done_cycle", cyc, d.cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int fsel, nd, badi, sidx, sn;
        bit cor;

        idle(3);
        @(negedge clk); check_reset("rst_hold");
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); check_reset("post_rst");
        @(posedge clk); #1;

        // Switch config, slot 1: two writes at 0x2200/0x2204.
        build_pkt(1, 3, FMT_SWITCH_CFG, 1, 1'b0, 0);
        send_pkt(-1, 0, 0);
        idle(3);

        // Long write, 4 data words, good CRC then corrupted CRC.
        build_pkt(0, 5, FMT_LONG_WRITE, 4, 1'b0, 0);
        send_pkt(-1, 0, 0);
        idle(3);
        build_pkt(0, 5, FMT_LONG_WRITE, 4, 1'b1, 0);
        send_pkt(-1, 0, 0);
        idle(3);

        // Memory backpressure for 3 cycles on data word 2.
        build_pkt(2, 7, FMT_LONG_WRITE, 4, 1'b0, 0);
        send_pkt(2, 3, 0);
        idle(3);

        // Slot 1 not free: header must wait, then go through the cycle the slot frees.
        slot_free = 4'b1101;
        build_pkt(1, 9, FMT_LONG_WRITE, 2, 1'b0, 0);
        flit = pf[0]; flit_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("blocked_ready", flit_ready, 0);
            chk("blocked_wen", rx_if.wen, 0);
            @(posedge clk); #1;
        end
        slot_free = 4'hF;
        @(negedge clk);
        chk("unblocked_ready", flit_ready, 1);
        @(posedge clk); #1;
        flit_valid = 1'b0;
        for (int i = 1; i < pf.size(); i++) send_flit(i, 0);
        idle(3);

        // Metadata mismatch: id 2 on flit 1 of slot 0; then a req mismatch on slot 3.
        build_pkt(0, 2, FMT_LONG_WRITE, 3, 1'b0, 1);
        send_pkt(-1, 0, 0);
        idle(3);
        build_pkt(3, 4, FMT_MSG, 2, 1'b0, 2);
        send_pkt(-1, 0, 0);
        idle(3);

        // Reset in the middle of a packet: no completion, everything back to reset values.
        build_pkt(2, 6, FMT_LONG_WRITE, 5, 1'b0, 0);
        send_flit(0, 0);
        send_flit(1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); check_reset("rst_mid");
        @(posedge clk); #1;
        wq.delete();
        idle(4);

        // Randomized packets back to back.
        for (int p = 0; p < 30; p++) begin
            fsel = $urandom_range(0, 3);
            nd   = $urandom_range(0, 6);
            cor  = ($urandom_range(0, 3) == 0);
            badi = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nd + 1) : 0;
            build_pkt($urandom_range(0, 3), $urandom_range(0, 15), format_e'(4'(fsel)), nd, cor, badi);
            sidx = $urandom_range(0, pf.size());
            sn   = $urandom_range(0, 3);
            send_pkt(sidx, sn, 2);
        end
        idle(6);

        chk("writes_drained", wq.size(), 0);
        chk("dones_drained", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
